// File: rtl/uart_frame_tx_pkg.sv
// -----------------------------------------------------------------------------
// uart_frame_tx_pkg
// Shared constants and types for the UART serial transmit stage.
//   CLKS_PER_BIT_DEF : default clock cycles per serial bit (100 MHz / 9600 baud)
//   FRAME_W          : frame width including start and stop bits
//   START_BIT        : bit position of the start bit inside a frame
//   STOP_BIT         : bit position of the stop bit inside a frame
//   IDLE_LVL         : level of the serial line when nothing is being sent
//   tx_state_e       : transmit FSM state encoding
// -----------------------------------------------------------------------------
package uart_frame_tx_pkg;

  localparam int   CLKS_PER_BIT_DEF = 10417;
  localparam int   FRAME_W          = 10;
  localparam int   START_BIT        = 0;
  localparam int   STOP_BIT         = FRAME_W - 1;
  localparam logic IDLE_LVL         = 1'b1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } tx_state_e;

endpackage : uart_frame_tx_pkg

// File: rtl/uart_baud_cnt.sv
// -----------------------------------------------------------------------------
// uart_baud_cnt
// Bit-period counter shared by the UART transmit and receive stages. Counts
// 0..CLKS_PER_BIT-1 while enabled and wraps; a synchronous clear forces it
// back to zero (clear has priority over enable).
// Ports:
//   i_clk     : system clock, rising edge
//   i_rst_n   : asynchronous reset, active-low
//   i_en      : count enable
//   i_clr     : synchronous clear to zero
//   o_bit_end : high in the last cycle of a bit period (count at terminal
//               value while enabled)
// -----------------------------------------------------------------------------
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = uart_frame_tx_pkg::CLKS_PER_BIT_DEF
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_bit_end
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_at_last;

  assign w_at_last = (r_cnt == LAST_CNT);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      if (w_at_last) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_bit_end = i_en & w_at_last;

endmodule : uart_baud_cnt

// File: rtl/uart_frame_tx.sv
// -----------------------------------------------------------------------------
// uart_frame_tx
// Serial transmit stage. Takes a pre-formatted frame {stop, data, start} from
// the upstream stage over a rdy/confirm handshake into a one-entry holding
// register, then shifts it out LSB-first, one bit every CLKS_PER_BIT clocks.
// While a frame is on the line the next one can already be parked in the
// holding register; it follows the current stop bit with no idle gap.
// Ports:
//   clk      : system clock, rising edge
//   rst      : asynchronous reset, active-low
//   frame_in : frame from upstream (bit 0 = start, MSB = stop), valid with rdy
//   rdy      : upstream has a frame ready (level, held until confirm is seen)
//   confirm  : one-cycle pulse, frame_in has been captured
//   TX       : serial line, idle high
//   busy     : a frame is shifting or the holding register is occupied
// -----------------------------------------------------------------------------
module uart_frame_tx #(
  parameter int CLKS_PER_BIT = uart_frame_tx_pkg::CLKS_PER_BIT_DEF,
  parameter int FRAME_W      = uart_frame_tx_pkg::FRAME_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [FRAME_W-1:0] frame_in,
  input  logic               rdy,
  output logic               confirm,
  output logic               TX,
  output logic               busy
);

  import uart_frame_tx_pkg::*;

  localparam int BIT_W = $clog2(FRAME_W);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_W - 1);

  tx_state_e          r_state;
  tx_state_e          w_state_nxt;
  logic [FRAME_W-1:0] r_shift;
  logic [FRAME_W-1:0] w_shift_nxt;
  logic [FRAME_W-1:0] r_hold;
  logic [FRAME_W-1:0] w_hold_nxt;
  logic               r_hold_full;
  logic               w_hold_full_nxt;
  logic [BIT_W-1:0]   r_bit_cnt;
  logic [BIT_W-1:0]   w_bit_cnt_nxt;
  logic               r_confirm;
  logic               r_busy;

  logic w_bit_end;
  logic w_baud_en;
  logic w_baud_clr;
  logic w_take;
  logic w_capture;

  assign w_baud_en = (r_state == ST_SHIFT);

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .i_clk    (clk),
    .i_rst_n  (rst),
    .i_en     (w_baud_en),
    .i_clr    (w_baud_clr),
    .o_bit_end(w_bit_end)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, shift/hold datapath and handshake decisions
  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_bit_cnt_nxt = r_bit_cnt;
    w_take        = 1'b0;
    w_baud_clr    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (r_hold_full) begin
          w_take        = 1'b1;
          w_shift_nxt   = r_hold;
          w_bit_cnt_nxt = '0;
          w_baud_clr    = 1'b1;
          w_state_nxt   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (w_bit_end) begin
          if (r_bit_cnt == LAST_BIT) begin
            w_bit_cnt_nxt = '0;
            if (r_hold_full) begin
              // Reload straight after the stop bit: back-to-back frames.
              w_take      = 1'b1;
              w_shift_nxt = r_hold;
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end else begin
            // Fill with the idle level so a stale bit can never reach TX.
            w_shift_nxt   = {IDLE_LVL, r_shift[FRAME_W-1:1]};
            w_bit_cnt_nxt = r_bit_cnt + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // The previous-cycle confirm guard covers the one cycle in which upstream
    // still holds rdy after being confirmed. A transfer out of the holding
    // register takes precedence over a new capture in the same cycle.
    w_capture = rdy & ~r_hold_full & ~r_confirm & ~w_take;

    w_hold_nxt = w_capture ? frame_in : r_hold;
    if (w_take) begin
      w_hold_full_nxt = 1'b0;
    end else if (w_capture) begin
      w_hold_full_nxt = 1'b1;
    end else begin
      w_hold_full_nxt = r_hold_full;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shift     <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_bit_cnt   <= '0;
      r_confirm   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_shift     <= w_shift_nxt;
      r_hold      <= w_hold_nxt;
      r_hold_full <= w_hold_full_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_confirm   <= w_capture;
      // Built from next-state values so busy lines up with state/hold_full.
      r_busy      <= (w_state_nxt == ST_SHIFT) | w_hold_full_nxt;
    end
  end

  // TX decoded from state so reset forces the line idle without waiting for
  // a clock edge.
  assign TX      = (r_state == ST_SHIFT) ? r_shift[START_BIT] : IDLE_LVL;
  assign confirm = r_confirm;
  assign busy    = r_busy;

endmodule : uart_frame_tx

// File: tb/tb_uart_frame_tx.sv
module tb_uart_frame_tx;

  localparam int CPB = 16;
  localparam int FW  = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rdy = 1'b0;
  logic [FW-1:0] frame_in = '0;
  logic          confirm;
  logic          TX;
  logic          busy;

  always #5 clk = ~clk;

  uart_frame_tx #(
    .CLKS_PER_BIT(CPB),
    .FRAME_W     (FW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .frame_in(frame_in),
    .rdy     (rdy),
    .confirm (confirm),
    .TX      (TX),
    .busy    (busy)
  );

  typedef struct {
    logic [FW-1:0] f;
    bit            gap;
    bit            abort;
  } exp_t;

  exp_t exp_q[$];

  int n_tests    = 0;
  int n_fail     = 0;
  int cyc        = 0;
  int mon_start  = -1;
  int mon_end    = -100;
  bit mon_active = 1'b0;
  int conf_cnt   = 0;
  int wide       = 0;
  int exp_conf   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [FW-1:0] f, input bit gap, input bit abort);
    exp_t e;
    e.f     = f;
    e.gap   = gap;
    e.abort = abort;
    exp_q.push_back(e);
  endtask

  // Cycle counter, advanced on the active edge
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Confirm monitor: counts pulses and any pulse longer than one cycle
  initial begin
    bit prev_c;
    prev_c = 1'b0;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && confirm === 1'b1) begin
        if (prev_c) wide++;
        else        conf_cnt++;
      end
      prev_c = (rst === 1'b1 && confirm === 1'b1);
    end
  end

  // Serial line monitor: deserialises TX and compares against the scoreboard
  initial begin
    exp_t          e;
    logic [FW-1:0] got;
    int            bad;
    bit            ab;
    int            st;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1 || TX !== 1'b0) continue;
      st         = cyc;
      mon_start  = st;
      mon_active = 1'b1;
      got        = '0;
      bad        = 0;
      ab         = 1'b0;
      for (int b = 0; b < FW && !ab; b++) begin
        for (int s = 0; s < CPB; s++) begin
          if (!(b == 0 && s == 0)) @(negedge clk);
          if (rst !== 1'b1) begin
            ab = 1'b1;
            break;
          end
          if (s == 0) got[b] = TX;
          else if (TX !== got[b]) bad++;
        end
      end
      mon_active = 1'b0;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_frame: got %0h expected none", got);
      end else begin
        e = exp_q.pop_front();
        if (ab) begin
          check("frame_abort", 32'd1, {31'd0, e.abort});
        end else begin
          check("frame_abort", 32'd0, {31'd0, e.abort});
          check("frame_bits", {22'd0, got}, {22'd0, e.f});
          check("bit_hold_glitches", bad, 0);
          if (e.gap) check("no_idle_gap_start_cycle", st, mon_end + 1);
        end
      end
      if (!ab) mon_end = cyc;
    end
  end

  task automatic offer(input logic [FW-1:0] f, input bit hold_e1, input int bound,
                       output int conf_cyc);
    int n;
    bit got;
    n   = 0;
    got = 1'b0;
    frame_in = f;
    rdy      = 1'b1;
    exp_conf++;
    while (!got && n < bound) begin
      @(negedge clk);
      n++;
      if (confirm === 1'b1) got = 1'b1;
    end
    check("confirm_seen", {31'd0, got}, 32'd1);
    conf_cyc = cyc;
    if (hold_e1) @(negedge clk);
    rdy = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while ((busy !== 1'b0 || mon_active) && n < bound) begin
      @(negedge clk);
      n++;
    end
    check("idle_within_bound", {31'd0, (n < bound)}, 32'd1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int c1, c2, c3, d, txq, badc;

    // Reset state
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_TX", {31'd0, TX}, 32'd1);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_confirm", {31'd0, confirm}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Single frame 0x61, rdy dropped as soon as confirm is seen
    push_exp(10'h2C2, 1'b0, 1'b0);
    offer(10'h2C2, 1'b0, 50, c1);
    check("busy_after_capture", {31'd0, busy}, 32'd1);
    wait_idle(400);
    check("idle_TX", {31'd0, TX}, 32'd1);
    check("idle_busy", {31'd0, busy}, 32'd0);

    // rdy still high on the edge after confirm: exactly one capture
    push_exp(10'h2F4, 1'b0, 1'b0);
    offer(10'h2F4, 1'b1, 50, c1);
    wait_idle(400);

    // Back-to-back frames, third one waits for the holding register
    push_exp(10'h2C2, 1'b0, 1'b0);
    offer(10'h2C2, 1'b1, 50, c1);
    repeat (20) @(negedge clk);
    push_exp(10'h2F4, 1'b1, 1'b0);
    offer(10'h2F4, 1'b1, 10, c2);
    check("second_confirm_in_first_frame", {31'd0, (c2 - c1 < 10 * CPB)}, 32'd1);
    push_exp(10'h386, 1'b1, 1'b0);
    offer(10'h386, 1'b1, 400, c3);
    d = c3 - mon_start;
    n_tests++;
    if (d < 1 || d > 2) begin
      n_fail++;
      $display("FAIL third_confirm_delay: got %0d cycles after second start, expected 1..2", d);
    end
    wait_idle(800);

    // Reset during bit 4 with a second frame pending in the holding register
    push_exp(10'h34A, 1'b0, 1'b1);
    offer(10'h34A, 1'b1, 50, c1);
    repeat (20) @(negedge clk);
    offer(10'h2C2, 1'b1, 10, c2);
    repeat (50) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("midframe_reset_TX", {31'd0, TX}, 32'd1);
    check("midframe_reset_busy", {31'd0, busy}, 32'd0);
    check("midframe_reset_confirm", {31'd0, confirm}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    txq = 0;
    repeat (300) begin
      @(negedge clk);
      if (TX !== 1'b1 || busy !== 1'b0) txq++;
    end
    check("quiet_after_reset_release", txq, 0);

    // rdy high throughout reset: capture on the first edge after release
    rst      = 1'b0;
    frame_in = 10'h2F4;
    rdy      = 1'b1;
    badc     = 0;
    repeat (5) begin
      @(negedge clk);
      if (confirm !== 1'b0) badc++;
    end
    check("no_confirm_during_reset", badc, 0);
    push_exp(10'h2F4, 1'b0, 1'b0);
    exp_conf++;
    rst = 1'b1;
    @(negedge clk);
    check("confirm_after_release", {31'd0, confirm}, 32'd1);
    rdy = 1'b0;
    wait_idle(400);

    check("confirm_count", conf_cnt, exp_conf);
    check("wide_confirm_pulses", wide, 0);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_uart_frame_tx

// File: doc/uart_frame_tx.md
Name: uart_frame_tx

Overview:
- Serial transmit stage directly downstream of the UART receive/adjust stage.
- Accepts a pre-formatted 10-bit frame {stop, data[7:0], start} over a rdy/confirm handshake.
- Shifts the frame out LSB-first on a single serial line at the configured baud rate.
- A one-entry holding register lets the upstream stage hand over the next frame while the current one is still on the line.

Parameters:
- CLKS_PER_BIT, 10417, clock cycles per serial bit (100 MHz / 9600 baud); baud counter runs 0..CLKS_PER_BIT-1.
- FRAME_W, 10, frame width in bits including start and stop.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- frame_in  input  FRAME_W  frame from upstream, bit 0 = start, bit 9 = stop; valid while rdy=1.
- rdy  input  1  upstream has a frame ready; level, held until upstream sees confirm.
- confirm  output  1  single-cycle pulse: frame_in captured into holding register.
- TX  output  1  serial line, idle high.
- busy  output  1  1 while a frame is shifting or the holding register is full.

Behaviour:
- Reset (rst=0, asynchronous):
  - TX=1, confirm=0, busy=0.
  - Holding register empty, shift register cleared, counters 0, state IDLE.
- Capture rule:
  - At a clock edge where rdy=1, holding empty, and confirm was 0 on the previous cycle: latch frame_in into hold and set hold_full.
  - confirm=1 for exactly the next cycle.
- Upstream clears rdy one cycle after seeing confirm, so rdy is still 1 in the cycle after the confirm pulse. The previous-cycle-confirm guard blocks a double capture in that cycle.
- rdy=1 with holding full: no capture, confirm stays 0 until the slot frees.
- States:
  - IDLE: TX=1.
    - If hold_full: move hold into the shift register, clear hold_full, bit_cnt=0, baud_cnt=0, go to SHIFT.
    - TX shows the start bit (shift[0]) from the cycle after the transfer.
  - SHIFT: TX=shift[0]. baud_cnt increments each cycle. When baud_cnt==CLKS_PER_BIT-1:
    - baud_cnt=0.
    - If bit_cnt==FRAME_W-1: end of frame.
      - If hold_full: reload shift from hold, clear hold_full, bit_cnt=0, stay in SHIFT (back-to-back frames, no idle gap).
      - Else go to IDLE.
    - Otherwise shift right by 1 (fill with 1), bit_cnt+1.
- Bit timing: each bit, including stop, is held exactly CLKS_PER_BIT cycles.
- Capture into hold and transfer from hold in the same cycle: transfer wins, hold_full stays 0, capture waits one cycle.
- Frame bits are sent exactly as given. The block does not check or force start/stop values.
- busy = (state==SHIFT) | hold_full, registered.
- Reset mid-frame: TX returns to 1 immediately, pending hold is discarded, no confirm is issued for the lost frame.
- Counter widths: baud_cnt = clog2(CLKS_PER_BIT); bit_cnt = clog2(FRAME_W).

Decomposition:
- Shared package:
  - CLKS_PER_BIT default and FRAME_W.
  - Bit positions START_BIT=0, STOP_BIT=FRAME_W-1.
  - Line idle level IDLE_LVL=1.
  - State encoding {IDLE, SHIFT}.
- One natural sub-module, uart_baud_cnt: counter with enable and sync clear, emitting bit_end when count==CLKS_PER_BIT-1. It is reusable by the receive stage.

Test Plan (sim with CLKS_PER_BIT=16):
- Single frame 10'b1_0110_0001_0 (0x61), rdy pulsed until confirm:
  - One confirm pulse, 1 cycle wide.
  - TX sequence 0,1,0,0,0,0,1,1,0,1, each bit 16 cycles.
  - TX=1 and busy=0 afterwards.
- rdy held high 2 cycles after confirm (upstream model): exactly one capture, one frame on TX.
- Back-to-back frames 0x61 then 0x7A (second offered during the first frame):
  - Second confirm occurs during the first frame.
  - The second start bit follows the first stop bit with no idle gap; total 320 cycles.
- Third frame offered while shifting and hold full: confirm withheld until the first frame's stop bit ends, then issued within 2 cycles.
- rst=0 asserted at bit 4 of a frame: TX=1 immediately, busy=0, nothing transmitted after release until a new rdy.
- rdy=1 during reset: no confirm while rst=0; capture on the first edge after release.
